// File: rtl/xbus_pkg.sv
// Shared types and constants for the Xbus slave: handshake FSM states,
// disk register offsets and status bit positions.
package xbus_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StWait,
        StAck
    } xbus_state_e;

    localparam logic [1:0] DiskStatus = 2'd0;
    localparam logic [1:0] DiskMa     = 2'd1;
    localparam logic [1:0] DiskDa     = 2'd2;
    localparam logic [1:0] DiskEcc    = 2'd3;

    localparam int unsigned StatBusy  = 0;
    localparam int unsigned StatDone  = 1;
    localparam int unsigned StatIntEn = 2;

endpackage

// File: rtl/xbus_disk_regs.sv
// Four-register disk controller: status/ma/da/ecc with a busy countdown
// that completes an operation and raises a registered interrupt.
module xbus_disk_regs
    import xbus_pkg::*;
#(
    parameter int unsigned DATA_W           = 32,
    parameter int unsigned DISK_BUSY_CYCLES = 16
) (
    input  logic              mclk,
    input  logic              reset_n,
    input  logic              wr_en_i,
    input  logic [1:0]        sel_i,
    input  logic [DATA_W-1:0] wdata_i,
    output logic [DATA_W-1:0] rdata_o,
    output logic              int_o
);

    localparam int unsigned CntW = $clog2(DISK_BUSY_CYCLES + 1);

    logic [DATA_W-1:0] ma_q, ma_d, da_q, da_d, ecc_q, ecc_d;
    logic              busy_q, busy_d, done_q, done_d;
    logic              int_en_q, int_en_d, int_q, int_d;
    logic [CntW-1:0]   cnt_q, cnt_d;

    always_comb begin
        ma_d     = ma_q;
        da_d     = da_q;
        ecc_d    = ecc_q;
        busy_d   = busy_q;
        done_d   = done_q;
        int_en_d = int_en_q;
        cnt_d    = cnt_q;

        if (wr_en_i) begin
            unique case (sel_i)
                DiskStatus: begin
                    int_en_d = wdata_i[StatIntEn];
                    if (wdata_i[StatDone]) done_d = 1'b0;
                    if (wdata_i[StatBusy] && !busy_q) begin
                        busy_d = 1'b1;
                        done_d = 1'b0;
                        cnt_d  = CntW'(DISK_BUSY_CYCLES);
                    end
                end
                DiskMa:  ma_d  = wdata_i;
                DiskDa:  da_d  = wdata_i;
                DiskEcc: ecc_d = wdata_i;
                default: ;
            endcase
        end

        // Completion is evaluated last so it overrides same-cycle bus writes.
        if (busy_q) begin
            cnt_d = cnt_q - CntW'(1);
            if (cnt_q == CntW'(1)) begin
                busy_d = 1'b0;
                done_d = 1'b1;
                da_d   = da_q + DATA_W'(1);
                ecc_d  = '0;
            end
        end

        int_d = done_q & int_en_q;
    end

    always_ff @(posedge mclk) begin
        if (!reset_n) begin
            ma_q     <= '0;
            da_q     <= '0;
            ecc_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            int_en_q <= 1'b0;
            int_q    <= 1'b0;
            cnt_q    <= '0;
        end else begin
            ma_q     <= ma_d;
            da_q     <= da_d;
            ecc_q    <= ecc_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            int_en_q <= int_en_d;
            int_q    <= int_d;
            cnt_q    <= cnt_d;
        end
    end

    always_comb begin
        rdata_o = '0;
        unique case (sel_i)
            DiskStatus: begin
                rdata_o[StatBusy]  = busy_q;
                rdata_o[StatDone]  = done_q;
                rdata_o[StatIntEn] = int_en_q;
            end
            DiskMa:  rdata_o = ma_q;
            DiskDa:  rdata_o = da_q;
            DiskEcc: rdata_o = ecc_q;
            default: ;
        endcase
    end

    assign int_o = int_q;

endmodule

// File: rtl/xbus_slave_ctl.sv
// Clocked Xbus slave: 4-phase req/ack handshake with programmable wait states,
// a RAM window at address 0 and the disk register block. int_o is the disk interrupt.
module xbus_slave_ctl
    import xbus_pkg::*;
#(
    parameter int unsigned       ADDR_W           = 22,
    parameter int unsigned       DATA_W           = 32,
    parameter int unsigned       MEM_DEPTH        = 1024,
    parameter logic [ADDR_W-1:0] DISK_BASE        = 22'o17377774,
    parameter int unsigned       ACK_DELAY        = 2,
    parameter int unsigned       DISK_BUSY_CYCLES = 16
) (
    input  logic              mclk,
    input  logic              reset_n,
    input  logic              req,
    input  logic              wrcyc,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] bus_in,
    output logic [DATA_W-1:0] bus_out,
    output logic              bus_oe,
    output logic              ack_n,
    output logic              loadmd,
    output logic              memgrant_n,
    output logic              mempar_in,
    output logic              int_o
);

    localparam int unsigned IdxW  = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
    localparam int unsigned WaitW = (ACK_DELAY > 0) ? $clog2(ACK_DELAY + 1) : 1;

    xbus_state_e       state_q, state_d;
    logic [WaitW-1:0]  wait_q, wait_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              wr_q, wr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d, rdata_q, rdata_d;
    logic              memgrant_n_q;

    logic [DATA_W-1:0] mem [MEM_DEPTH];

    logic              access;
    logic              mem_hit, disk_hit;
    logic [ADDR_W-1:0] disk_off;
    logic [DATA_W-1:0] disk_rdata, rd_val;

    assign mem_hit  = addr_q < ADDR_W'(MEM_DEPTH);
    assign disk_off = addr_q - DISK_BASE;
    assign disk_hit = (addr_q >= DISK_BASE) && (disk_off < ADDR_W'(4));

    always_comb begin
        rd_val = '0;
        if (mem_hit)       rd_val = mem[addr_q[IdxW-1:0]];
        else if (disk_hit) rd_val = disk_rdata;
    end

    always_comb begin
        state_d = state_q;
        wait_d  = wait_q;
        addr_d  = addr_q;
        wr_d    = wr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        access  = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (req) begin
                    addr_d  = addr;
                    wr_d    = wrcyc;
                    wdata_d = bus_in;
                    wait_d  = WaitW'(ACK_DELAY);
                    state_d = StWait;
                end
            end
            StWait: begin
                // Master withdrawing req before ack aborts with no side effects.
                if (!req) begin
                    state_d = StIdle;
                end else if (wait_q == '0) begin
                    access  = 1'b1;
                    state_d = StAck;
                    if (!wr_q) rdata_d = rd_val;
                end else begin
                    wait_d = wait_q - WaitW'(1);
                end
            end
            StAck: begin
                if (!req) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge mclk) begin
        if (!reset_n) begin
            state_q      <= StIdle;
            wait_q       <= '0;
            addr_q       <= '0;
            wr_q         <= 1'b0;
            wdata_q      <= '0;
            rdata_q      <= '0;
            memgrant_n_q <= 1'b1;
        end else begin
            state_q      <= state_d;
            wait_q       <= wait_d;
            addr_q       <= addr_d;
            wr_q         <= wr_d;
            wdata_q      <= wdata_d;
            rdata_q      <= rdata_d;
            memgrant_n_q <= ~req;
        end
    end

    always_ff @(posedge mclk) begin
        if (reset_n && access && wr_q && mem_hit) begin
            mem[addr_q[IdxW-1:0]] <= wdata_q;
        end
    end

    xbus_disk_regs #(
        .DATA_W           (DATA_W),
        .DISK_BUSY_CYCLES (DISK_BUSY_CYCLES)
    ) u_disk_regs (
        .mclk    (mclk),
        .reset_n (reset_n),
        .wr_en_i (access && wr_q && disk_hit),
        .sel_i   (disk_off[1:0]),
        .wdata_i (wdata_q),
        .rdata_o (disk_rdata),
        .int_o   (int_o)
    );

    assign ack_n      = (state_q != StAck);
    assign bus_oe     = (state_q == StAck) && !wr_q;
    assign loadmd     = bus_oe;
    assign bus_out    = rdata_q;
    assign mempar_in  = ~^rdata_q;
    assign memgrant_n = memgrant_n_q;

endmodule

// File: tb/tb_xbus_slave_ctl.sv
// Directed bench for xbus_slave_ctl: handshake timing, RAM, disk block and reset,
// with read data checked against a scoreboard queue.
module tb_xbus_slave_ctl;

    localparam int          ACK_DELAY = 2;
    localparam logic [21:0] DISK_BASE = 22'o17377774;
    localparam logic [21:0] A_ST      = DISK_BASE;
    localparam logic [21:0] A_MA      = DISK_BASE + 22'd1;
    localparam logic [21:0] A_DA      = DISK_BASE + 22'd2;
    localparam logic [21:0] A_ECC     = DISK_BASE + 22'd3;

    logic        mclk    = 1'b0;
    logic        reset_n = 1'b0;
    logic        req     = 1'b0;
    logic        wrcyc   = 1'b0;
    logic [21:0] addr    = '0;
    logic [31:0] bus_in  = '0;
    logic [31:0] bus_out;
    logic        bus_oe, ack_n, loadmd, memgrant_n, mempar_in, int_o;

    int          checks = 0;
    int          errors = 0;
    int unsigned cyc    = 0;
    logic [31:0] sb[$];

    xbus_slave_ctl dut (
        .mclk       (mclk),
        .reset_n    (reset_n),
        .req        (req),
        .wrcyc      (wrcyc),
        .addr       (addr),
        .bus_in     (bus_in),
        .bus_out    (bus_out),
        .bus_oe     (bus_oe),
        .ack_n      (ack_n),
        .loadmd     (loadmd),
        .memgrant_n (memgrant_n),
        .mempar_in  (mempar_in),
        .int_o      (int_o)
    );

    always #5 mclk = ~mclk;
    always @(posedge mclk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One full 4-phase transfer; read data is checked against the scoreboard.
    task automatic xfer(input logic w, input logic [21:0] a, input logic [31:0] d,
                        output int unsigned ack_cyc);
        int          k;
        logic [31:0] e;
        @(posedge mclk); #1;
        req = 1'b1; wrcyc = w; addr = a; bus_in = d;
        @(posedge mclk); #1;
        k = 1;
        check("memgrant_low", {31'b0, memgrant_n}, 32'd0);
        while (ack_n && k < 20) begin
            @(posedge mclk); #1;
            k++;
        end
        ack_cyc = cyc;
        check("ack_latency", 32'(k), 32'(ACK_DELAY + 2));
        if (!w) begin
            e = sb.pop_front();
            check("rd_data", bus_out, e);
            check("rd_parity", {31'b0, mempar_in}, {31'b0, ~^e});
            check("rd_loadmd", {31'b0, loadmd}, 32'd1);
            check("rd_oe", {31'b0, bus_oe}, 32'd1);
        end else begin
            check("wr_oe", {31'b0, bus_oe}, 32'd0);
        end
        req = 1'b0;
        @(posedge mclk); #1;
        check("ack_release", {31'b0, ack_n}, 32'd1);
        check("oe_release", {31'b0, bus_oe}, 32'd0);
    endtask

    task automatic wr(input logic [21:0] a, input logic [31:0] d);
        int unsigned c;
        xfer(1'b1, a, d, c);
    endtask

    task automatic rd(input logic [21:0] a, input logic [31:0] e);
        int unsigned c;
        sb.push_back(e);
        xfer(1'b0, a, 32'd0, c);
    endtask

    task automatic wait_int(output int unsigned at);
        int k = 0;
        while (!int_o && k < 100) begin
            @(posedge mclk); #1;
            k++;
        end
        at = cyc;
        check("int_rise", {31'b0, int_o}, 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned c_go, c_int;
        int          k;
        logic        acked;

        repeat (2) @(posedge mclk);
        #1;
        check("rst_ack_n", {31'b0, ack_n}, 32'd1);
        check("rst_oe", {31'b0, bus_oe}, 32'd0);
        check("rst_loadmd", {31'b0, loadmd}, 32'd0);
        check("rst_bus_out", bus_out, 32'd0);
        check("rst_memgrant", {31'b0, memgrant_n}, 32'd1);
        check("rst_int", {31'b0, int_o}, 32'd0);
        reset_n = 1'b1;

        wr(22'd5, 32'o1234);
        rd(22'd5, 32'o1234);

        // Disk operation: completion increments da, clears ecc, raises int.
        wr(A_DA, 32'd7);
        wr(A_ECC, 32'o55);
        xfer(1'b1, A_ST, 32'o5, c_go);
        rd(A_ST, 32'o5);
        wait_int(c_int);
        check("done_latency", 32'(c_int - c_go), 32'd17);
        rd(A_ST, 32'o6);
        rd(A_DA, 32'o10);
        rd(A_ECC, 32'd0);
        xfer(1'b1, A_ST, 32'o2, c_go);
        check("int_cleared", {31'b0, int_o}, 32'd0);
        rd(A_ST, 32'd0);

        // Abort a write to ma during wait states.
        @(posedge mclk); #1;
        req = 1'b1; wrcyc = 1'b1; addr = A_MA; bus_in = 32'o777;
        @(posedge mclk); #1;
        req = 1'b0;
        acked = 1'b0;
        repeat (6) begin
            @(posedge mclk); #1;
            if (!ack_n) acked = 1'b1;
        end
        check("abort_no_ack", {31'b0, acked}, 32'd0);
        rd(A_MA, 32'd0);

        // Unmapped read returns zero after a nonzero read.
        rd(22'd5, 32'o1234);
        rd(22'o100000, 32'd0);

        // Second go while busy must not reload the countdown.
        xfer(1'b1, A_ST, 32'o5, c_go);
        wr(A_ST, 32'o5);
        wait_int(c_int);
        check("busy_go_latency", 32'(c_int - c_go), 32'd17);
        rd(A_DA, 32'o11);

        // Reset while in the ack phase of a read.
        @(posedge mclk); #1;
        req = 1'b1; wrcyc = 1'b0; addr = 22'd5;
        k = 0;
        while (ack_n && k < 20) begin
            @(posedge mclk); #1;
            k++;
        end
        check("pre_rst_ack", {31'b0, ack_n}, 32'd0);
        check("pre_rst_int", {31'b0, int_o}, 32'd1);
        reset_n = 1'b0;
        @(posedge mclk); #1;
        check("mid_rst_ack_n", {31'b0, ack_n}, 32'd1);
        check("mid_rst_oe", {31'b0, bus_oe}, 32'd0);
        check("mid_rst_bus_out", bus_out, 32'd0);
        check("mid_rst_int", {31'b0, int_o}, 32'd0);
        req = 1'b0;
        reset_n = 1'b1;
        rd(A_ST, 32'd0);
        rd(A_DA, 32'd0);
        rd(22'd5, 32'o1234);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/xbus_slave_ctl.md
Name: xbus_slave_ctl

Overview:
Parametrised, fully synchronous Xbus slave for the CADR memory/IO bus. It answers req/wrcyc cycles with a programmable wait-state ack. Behind it sit a RAM window at the bottom of the address space and a four-register disk controller block. The disk block has busy/done/interrupt semantics. Replaces the async, event-driven simulation stub with clocked RTL usable on FPGA.

Parameters:
ADDR_W, 22, Xbus address width
DATA_W, 32, bus data width
MEM_DEPTH, 1024, RAM window words, mapped at addresses 0..MEM_DEPTH-1; must be < DISK_BASE
DISK_BASE, 22'o17377774, base of 4-word disk register block
ACK_DELAY, 2, wait states between req sample and ack (0 allowed)
DISK_BUSY_CYCLES, 16, mclk cycles a disk "go" stays busy (>=1)

Ports:
mclk  in  1  clock, all logic on rising edge
reset_n  in  1  reset, synchronous, active-low
req  in  1  master request, level, held until ack seen
wrcyc  in  1  1=write, 0=read; valid with req
addr  in  ADDR_W  address; valid with req
bus_in  in  DATA_W  write data; valid with req
bus_out  out  DATA_W  read data
bus_oe  out  1  drive enable for bus_out (read ack phase only)
ack_n  out  1  active-low acknowledge
loadmd  out  1  high with ack on reads (MD load strobe)
memgrant_n  out  1  registered ~req
mempar_in  out  1  odd parity of bus_out
int  out  1  disk interrupt = done & int_en

Behaviour:
- Reset (reset_n=0 at edge): state IDLE; ack_n=1, loadmd=0, bus_oe=0, bus_out=0, memgrant_n=1, int=0. Disk regs ma/da/ecc=0, status=0, busy counter=0. RAM contents are not reset. Reset mid-cycle aborts with no commit.
- FSM IDLE/WAIT/ACK:
  - IDLE: req=1 at edge N -> capture addr/wrcyc/bus_in, load wait counter=ACK_DELAY, go WAIT.
  - WAIT: counter=0 -> perform access (write commit or read-data latch), go ACK; else decrement.
  - ack_n first low after edge N+ACK_DELAY+1.
  - WAIT with req=0 -> abort, IDLE, no write commit, no side effects.
  - ACK: ack_n=0; loadmd=bus_oe=~wrcyc_captured; bus_out holds read data. Held until req sampled 0 -> IDLE, ack_n=1, bus_oe=0 next cycle (4-phase handshake). A new req is accepted only from IDLE.
- Decode on captured addr:
  - addr<MEM_DEPTH -> RAM[addr].
  - DISK_BASE+0..3 -> status, ma, da, ecc.
  - Anything else: read returns 0, write ignored, ack still given.
- Status read: bit0 busy, bit1 done, bit2 int_en, rest 0.
- Status write:
  - bit2 -> int_en.
  - bit1=1 clears done.
  - bit0=1 while !busy -> busy=1, done=0, counter=DISK_BUSY_CYCLES. bit0=1 while busy is ignored (int_en/done-clear still apply).
- Busy countdown reaching 0 sets busy=0 and done=1 in one cycle, increments da mod 2^DATA_W, and clears ecc.
  - Countdown completion and a same-cycle done-clear write: completion wins, done=1.
  - Countdown completion and a same-cycle write to da: completion's increment wins.
- ma/da/ecc: plain R/W, full DATA_W.
- int registered: int = done & int_en, updated one cycle after either changes.
- memgrant_n = ~req delayed one mclk.

Decomposition:
- Package xbus_pkg:
  - FSM state enum (IDLE, WAIT, ACK).
  - Disk register offsets (STATUS=0, MA=1, DA=2, ECC=3).
  - Status bit indices (BUSY=0, DONE=1, INT_EN=2).
- Sub-module xbus_disk_regs: register block plus busy counter and int.
- Top module: handshake FSM, decode, RAM.

Test Plan:
- ACK_DELAY=2, write 32'o1234 to addr 5, then read addr 5:
  - Each cycle: ack_n low exactly 3 cycles after req sampled.
  - Read: bus_out=32'o1234, loadmd=1, mempar_in=odd parity.
  - Ack released the cycle after req drops.
- Write da=7, write status=32'o5 (go+int_en):
  - Status reads busy=1.
  - After 16 cycles: done=1, da reads 10, ecc=0, int=1.
  - Writing status=2 clears done and int.
- Req dropped during WAIT of a write to ma=32'o777 -> no ack, ma still reads 0.
- Read unmapped address 22'o100000 -> ack given, bus_out=0.
- Go write while busy -> busy counter not reloaded; done at original time.
- reset_n=0 during ACK phase -> next cycle ack_n=1, bus_oe=0, regs 0, int=0; RAM data written earlier still reads back.
